// File: rtl/vend_change_ctrl.sv
// vend_change_ctrl: priced vending sequencer. Collects 5/10-cent coins,
// requests a product once credit reaches PRICE, and pays back excess or
// cancelled credit as one 5-cent change pulse per cycle.
module vend_change_ctrl #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic                change_out,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        RETURN   = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_reject_q, coin_reject_d;

    logic [CREDIT_W-1:0] coin_add;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] credit_rem;

    // State, credit and reject-pulse registers; reset discards any credit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= COLLECT;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Next-state and credit arithmetic for the three-state sequencer.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;

        // Coin value in 5-cent units; the invalid code contributes nothing.
        case (coin)
            2'b01:   coin_add = ONE_C;
            2'b10:   coin_add = CREDIT_W'(2);
            default: coin_add = '0;
        endcase

        // Max reachable credit is PRICE+1, which fits for legal PRICE values.
        credit_sum = credit_q + coin_add;
        credit_rem = credit_q - PRICE_C;

        case (state_q)
            COLLECT: begin
                coin_reject_d = (coin == 2'b11);
                credit_d      = credit_sum;
                // Reaching the price wins over a simultaneous cancel.
                if (credit_sum >= PRICE_C) begin
                    state_d = DISPENSE;
                end else if (cancel && (credit_sum != '0)) begin
                    state_d = RETURN;
                end
            end
            DISPENSE: begin
                // Coin path is closed while the dispenser is working.
                coin_reject_d = (coin != 2'b00);
                if (disp_ack) begin
                    credit_d = credit_rem;
                    state_d  = (credit_rem != '0) ? RETURN : COLLECT;
                end
            end
            RETURN: begin
                coin_reject_d = (coin != 2'b00);
                // One change coin per cycle; the last one lands back in COLLECT.
                if (credit_q <= ONE_C) begin
                    credit_d = '0;
                    state_d  = COLLECT;
                end else begin
                    credit_d = credit_q - ONE_C;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = COLLECT;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        disp_req    = (state_q == DISPENSE);
        change_out  = (state_q == RETURN);
        busy        = (state_q != COLLECT);
        coin_reject = coin_reject_q;
        credit      = credit_q;
    end

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Directed bench for vend_change_ctrl with PRICE=3, CREDIT_W=4. Each step
// drives one cycle of inputs, queues the outputs expected after that edge,
// then pops and compares them once the edge has passed.
module tb_vend_change_ctrl;

    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;

    logic                clock;
    logic                reset;
    logic [1:0]          coin;
    logic                cancel;
    logic                disp_ack;
    logic                disp_req;
    logic                change_out;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;

    typedef struct {
        string               tag;
        logic [CREDIT_W-1:0] credit;
        logic                req;
        logic                chg;
        logic                rej;
        logic                busy;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    vend_change_ctrl #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .coin        (coin),
        .cancel      (cancel),
        .disp_ack    (disp_ack),
        .disp_req    (disp_req),
        .change_out  (change_out),
        .coin_reject (coin_reject),
        .busy        (busy),
        .credit      (credit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input string field,
                         input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, compare after the edge.
    task automatic step(input string tag, input logic rst_i,
                        input logic [1:0] coin_i, input logic cancel_i,
                        input logic ack_i, input logic [CREDIT_W-1:0] e_credit,
                        input logic e_req, input logic e_chg,
                        input logic e_rej, input logic e_busy);
        exp_t e;
        exp_t g;
        e.tag    = tag;
        e.credit = e_credit;
        e.req    = e_req;
        e.chg    = e_chg;
        e.rej    = e_rej;
        e.busy   = e_busy;
        reset    = rst_i;
        coin     = coin_i;
        cancel   = cancel_i;
        disp_ack = ack_i;
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        check(g.tag, "credit",      8'(credit),      8'(g.credit));
        check(g.tag, "disp_req",    8'(disp_req),    8'(g.req));
        check(g.tag, "change_out",  8'(change_out),  8'(g.chg));
        check(g.tag, "coin_reject", 8'(coin_reject), 8'(g.rej));
        check(g.tag, "busy",        8'(busy),        8'(g.busy));
    endtask

    initial begin
        reset    = 1'b1;
        coin     = 2'b00;
        cancel   = 1'b0;
        disp_ack = 1'b0;
        #1;
        //    tag          rst coin  can ack cred req chg rej busy
        step("rst0",       1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);
        step("rst1",       1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);

        // Exact price with three 5-cent coins, ack two cycles later.
        step("t1_c1",      0, 2'b01, 0, 0, 4'd1, 0, 0, 0, 0);
        step("t1_c2",      0, 2'b01, 0, 0, 4'd2, 0, 0, 0, 0);
        step("t1_c3",      0, 2'b01, 0, 0, 4'd3, 1, 0, 0, 1);
        step("t1_w1",      0, 2'b00, 0, 0, 4'd3, 1, 0, 0, 1);
        step("t1_w2",      0, 2'b00, 0, 0, 4'd3, 1, 0, 0, 1);
        step("t1_ack",     0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0);
        step("t1_idle",    0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);

        // Overpay with two 10-cent coins: one change pulse after ack.
        step("t2_c1",      0, 2'b10, 0, 0, 4'd2, 0, 0, 0, 0);
        step("t2_c2",      0, 2'b10, 0, 0, 4'd4, 1, 0, 0, 1);
        step("t2_ack",     0, 2'b00, 0, 1, 4'd1, 0, 1, 0, 1);
        step("t2_end",     0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);
        step("t2_idle",    0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);

        // Cancel refunds; coin with cancel is added then refunded.
        step("t3_c1",      0, 2'b01, 0, 0, 4'd1, 0, 0, 0, 0);
        step("t3_can",     0, 2'b00, 1, 0, 4'd1, 0, 1, 0, 1);
        step("t3_end",     0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);
        step("t3_cc",      0, 2'b10, 1, 0, 4'd2, 0, 1, 0, 1);
        step("t3_rjret",   0, 2'b01, 0, 0, 4'd1, 0, 1, 1, 1);
        step("t3_end2",    0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);

        // Coins and cancel in DISPENSE are rejected / ignored.
        step("t4_c1",      0, 2'b10, 0, 0, 4'd2, 0, 0, 0, 0);
        step("t4_c2",      0, 2'b01, 0, 0, 4'd3, 1, 0, 0, 1);
        step("t4_rj01",    0, 2'b01, 0, 0, 4'd3, 1, 0, 1, 1);
        step("t4_gap",     0, 2'b00, 0, 0, 4'd3, 1, 0, 0, 1);
        step("t4_rj11",    0, 2'b11, 0, 0, 4'd3, 1, 0, 1, 1);
        step("t4_can",     0, 2'b00, 1, 0, 4'd3, 1, 0, 0, 1);
        step("t4_ack",     0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0);

        // COLLECT corner cases: invalid coin, stray ack, cancel at zero.
        step("t5_rj11",    0, 2'b11, 0, 0, 4'd0, 0, 0, 1, 0);
        step("t5_ack",     0, 2'b00, 0, 1, 4'd0, 0, 0, 0, 0);
        step("t5_can0",    0, 2'b00, 1, 0, 4'd0, 0, 0, 0, 0);
        step("t5_cd",      0, 2'b10, 0, 1, 4'd2, 0, 0, 0, 0);
        step("t5_thr",     0, 2'b10, 1, 0, 4'd4, 1, 0, 0, 1);
        step("t5_ack",     0, 2'b00, 0, 1, 4'd1, 0, 1, 0, 1);
        step("t5_end",     0, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);

        // Reset in the middle of a refund discards the remaining credit.
        step("t6_cc",      0, 2'b10, 1, 0, 4'd2, 0, 1, 0, 1);
        step("t6_rst",     1, 2'b00, 0, 0, 4'd0, 0, 0, 0, 0);
        step("t6_c1",      0, 2'b01, 0, 0, 4'd1, 0, 0, 0, 0);
        step("t6_idle",    0, 2'b00, 0, 0, 4'd1, 0, 0, 0, 0);

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vend_change_ctrl.md
# vend_change_ctrl

Multi-coin vending sequencer with change return. Accumulates credit from 5/10-cent coins and requests a product from the dispenser via a req/ack handshake once credit reaches PRICE. Returns any excess or cancelled credit as single 5-cent change pulses. Sits between the coin acceptor and the dispenser/change-hopper mechanics, replacing fixed-price single-shot logic with a priced, refunding controller.

## Interface
- PRICE, 3: product price in 5-cent units (3 = 15 cents); legal range 1..(2^CREDIT_W − 2).
- CREDIT_W, 4: width of the credit register, in 5-cent units.

- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset; one clock; the polarity and synchronicity are fixed.
- coin  in  2  coin presented this cycle: 00 none, 01 5-cent, 10 10-cent, 11 invalid; sampled every edge, one code per physical coin.
- cancel  in  1  refund request, sampled every edge.
- disp_ack  in  1  dispenser has delivered the product.
- disp_req  out  1  product request; held until acknowledged.
- change_out  out  1  one 5-cent coin returned per high cycle.
- coin_reject  out  1  one-cycle pulse: the coin sampled at the previous edge was not accepted (physically diverted).
- busy  out  1  high whenever state ≠ COLLECT.
- credit  out  CREDIT_W  current credit in 5-cent units.

## Operation
- States: COLLECT, DISPENSE, RETURN. All outputs except credit are Moore/registered; disp_req = (state==DISPENSE), change_out = (state==RETURN), busy = (state≠COLLECT).
- Reset: state COLLECT, credit 0, coin_reject 0, so disp_req/change_out/busy 0.
- COLLECT:
  - coin 01 adds 1, coin 10 adds 2 to credit; coin 11 is not added and coin_reject pulses.
  - If the new credit ≥ PRICE, go to DISPENSE. Cancel is ignored in that same cycle.
  - Otherwise, cancel with new credit > 0 goes to RETURN. A coin arriving with cancel is added first, then refunded.
  - Cancel with credit 0 is ignored.
- DISPENSE:
  - Any coin 01/10/11 is rejected (coin_reject pulses, credit unchanged). Cancel is ignored.
  - On disp_ack: credit ← credit − PRICE. Next state is RETURN if the remainder > 0, else COLLECT.
- RETURN:
  - Each cycle, credit decrements by 1, and change_out is high that cycle.
  - When credit==1 at the edge, credit becomes 0 and the next state is COLLECT. Exactly N pulses are produced for credit N.
  - Coins are rejected. Cancel is ignored.
- Width rule: maximum credit is PRICE+1 (PRICE−1 plus a 10-cent coin). Subtraction never underflows. No saturation logic is needed provided PRICE respects the legal range.
- disp_ack outside DISPENSE has no effect.

## Timing
- Coin sampled at edge k: credit updated after edge k. If the PRICE threshold is reached, disp_req is high from edge k.
- disp_ack may arrive in the first disp_req cycle. disp_req drops at the edge that samples disp_ack.
- The first change_out cycle immediately follows the ack edge (or the cancel edge). Pulses are back-to-back, one per cycle.
- Between a rejected coin's sampling edge and coin_reject: 1 cycle.
- After the last change pulse, the block is in COLLECT and accepts a coin at the very next edge.
- Reset mid-operation (any state): credit is discarded with no refund, and all outputs are low after the reset edge.

## Test plan
- PRICE=3, coins 01,01,01 on consecutive edges → credit 1,2,3; disp_req high after the 3rd edge. Ack 2 cycles later → disp_req low, credit 0, no change_out, busy low.
- Coins 10,10 → credit 4, disp_req. Ack → credit 1, exactly one change_out cycle, then COLLECT with credit 0.
- Coin 01 then cancel → one change_out cycle, credit 0. Coin 10 together with cancel from credit 0 → credit 2, then two change_out cycles.
- While in DISPENSE, present coins 01 and 11 → coin_reject pulses each one cycle later, credit unchanged. Cancel in DISPENSE ignored.
- Coin 11 in COLLECT → coin_reject pulse, credit unchanged. disp_ack in COLLECT has no effect. Cancel with credit 0 is ignored.
- Reset asserted in the middle of RETURN (credit 2, after one pulse) → after the edge, credit 0, change_out/busy/disp_req 0, and a 01 coin is accepted on the next edge.
